// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Purpose:
//   Shares the single RAM port between four requesters: the instruction fetch
//   and data ports of core0 and core1. Class priority is data write, then data
//   read, then instruction read. Within a class the two cores take turns
//   through a per-class round-robin pointer. The arbiter drives the RAM
//   request signals and returns wait/load to the requester that holds the
//   grant.
//
// Optional feature (macro RAM_ARB_STARVE_GUARD_EN):
//   Defined   : each core has a 4-bit saturating starvation counter. A pending
//               iREN whose counter has reached STARVE_LIMIT outranks every
//               data class.
//   Undefined : strict class priority; instruction fetch can starve.
//
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   iREN / iaddr    per-core instruction read request and address
//   dREN / dWEN     per-core data read / write request
//   daddr / dstore  per-core data address and write value
//   iwait / dwait   per-core wait; 0 means the transfer completes this cycle
//   iload / dload   per-core return data (sentinel while not granted)
//   ramREN/ramWEN   RAM read / write enable
//   ramaddr         RAM address
//   ramstore        RAM write data
//   ramload         RAM read data
//   ramstate        RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   gnt_valid       a grant is active
//   gnt_core        core that holds the grant
//   gnt_kind        grant type: 0=IR, 1=DR, 2=DW
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int CPUS         = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate,
    output logic                  gnt_valid,
    output logic                  gnt_core,
    output logic [1:0]            gnt_kind
);

    // The arbitration logic is written for exactly two cores, and the
    // starvation counter is 4 bits wide.
    if (CPUS != 2 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
        $error("ram_arbiter: CPUS must be 2 and STARVE_LIMIT must be 1..15");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    typedef enum logic [1:0] {KIND_IR = 2'd0, KIND_DR = 2'd1, KIND_DW = 2'd2} kind_t;

    localparam logic [1:0]       RAM_ACCESS    = 2'd2;
    localparam logic [1:0][31:0] LOAD_SENTINEL = {32'hBAD1BAD1, 32'hBAD0BAD0};

    state_t     state, next_state;
    kind_t      gnt_kind_q;
    logic       gnt_core_q;
    logic       rr_ir, rr_dr, rr_dw;

    kind_t      win_kind;
    logic       win_valid;
    logic       win_core;
    logic [1:0] dr_req;
    logic [1:0] promoted;
    logic       req_held;
    logic       complete;
    logic       abort;

    // Both cores requesting: the pointer decides. Otherwise the only requester wins.
    function automatic logic pick(input logic [1:0] req, input logic ptr);
        return (req == 2'b11) ? ptr : req[1];
    endfunction

    // A core raising dREN and dWEN together is treated as a write only.
    assign dr_req = dREN & ~dWEN;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic [CPUS-1:0][3:0] starve_cnt;

    always_comb begin
        promoted = '0;
        for (int k = 0; k < CPUS; k++) begin
            promoted[k] = iREN[k] && (int'(starve_cnt[k]) >= STARVE_LIMIT);
        end
    end

    // A counter grows each IDLE cycle in which its core fetches but loses to a
    // data class. It clears when that core's fetch is granted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (state == IDLE && win_valid) begin
            for (int k = 0; k < CPUS; k++) begin
                if (win_kind == KIND_IR && win_core == 1'(k)) begin
                    starve_cnt[k] <= '0;
                end else if (iREN[k] && win_kind != KIND_IR && starve_cnt[k] != 4'hF) begin
                    starve_cnt[k] <= starve_cnt[k] + 4'd1;
                end
            end
        end
    end
`else
    assign promoted = '0;
`endif

    // Class arbitration on the current request vector. A promoted (starved)
    // fetch is ranked first.
    always_comb begin
        win_valid = 1'b1;
        win_core  = 1'b0;
        win_kind  = KIND_IR;
        if (promoted != 2'b00) begin
            win_core = pick(promoted, rr_ir);
        end else if (dWEN != 2'b00) begin
            win_kind = KIND_DW;
            win_core = pick(dWEN, rr_dw);
        end else if (dr_req != 2'b00) begin
            win_kind = KIND_DR;
            win_core = pick(dr_req, rr_dr);
        end else if (iREN != 2'b00) begin
            win_core = pick(iREN, rr_ir);
        end else begin
            win_valid = 1'b0;
        end
    end

    // The request bit that keeps the current grant alive.
    always_comb begin
        case (gnt_kind_q)
            KIND_IR: req_held = iREN[gnt_core_q];
            KIND_DR: req_held = dREN[gnt_core_q];
            default: req_held = dWEN[gnt_core_q];
        endcase
    end

    // A completion takes priority over a withdrawal in the same cycle.
    assign complete = (state == GRANT) && (ramstate == RAM_ACCESS);
    assign abort    = (state == GRANT) && !complete && !req_held;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            gnt_core_q <= 1'b0;
            gnt_kind_q <= KIND_IR;
            rr_ir      <= 1'b0;
            rr_dr      <= 1'b0;
            rr_dw      <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && win_valid) begin
                gnt_core_q <= win_core;
                gnt_kind_q <= win_kind;
            end
            // The pointer moves only on a real completion, never on an abort.
            if (complete) begin
                case (gnt_kind_q)
                    KIND_IR: rr_ir <= ~gnt_core_q;
                    KIND_DR: rr_dr <= ~gnt_core_q;
                    default: rr_dw <= ~gnt_core_q;
                endcase
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid) next_state = GRANT;
            GRANT:   if (complete || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The RAM drive follows the latched grant for the whole GRANT state, so
    // BUSY, FREE and ERROR simply hold it. Only ACCESS releases the granted wait bit.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = LOAD_SENTINEL;
        dload    = LOAD_SENTINEL;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == GRANT) begin
            case (gnt_kind_q)
                KIND_IR: begin
                    ramREN              = 1'b1;
                    ramaddr             = iaddr[gnt_core_q];
                    iload[gnt_core_q]   = ramload;
                    iwait[gnt_core_q]   = !complete;
                end
                KIND_DR: begin
                    ramREN              = 1'b1;
                    ramaddr             = daddr[gnt_core_q];
                    dload[gnt_core_q]   = ramload;
                    dwait[gnt_core_q]   = !complete;
                end
                default: begin
                    ramWEN              = 1'b1;
                    ramaddr             = daddr[gnt_core_q];
                    ramstore            = dstore[gnt_core_q];
                    dload[gnt_core_q]   = ramload;
                    dwait[gnt_core_q]   = !complete;
                end
            endcase
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_core  = gnt_core_q;
    assign gnt_kind  = gnt_kind_q;

endmodule
